axi_read_arbiter: RTL and testbench

- Parametrised N-port AXI read-channel arbiter between the reference readers and the single AXI read port.
- AR channel: round-robin selection among eligible ports, port index tagged into the upper ARID bits, request held in a registered AR stage.
- R channel: beats routed back by RID port field.
- Per-port outstanding-burst counters throttle each port; beats for an unknown port are flagged and dropped.

---
 rtl/axi_arb_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/axi_read_arbiter.sv | 118 +++++++++++
 tb/tb_axi_read_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared helpers for the AXI read arbiter: width derivation and the
// ARID/RID layout ({port index, per-port burst ID}).
package axi_arb_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Port field is never narrower than one bit, even for two ports.
  function automatic int port_idx_w(input int n);
    return (n > 2) ? clog2(n) : 1;
  endfunction

  // Port field sits directly above the per-port burst ID.
  function automatic int port_lsb(input int id_w);
    return id_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after prio, one-hot grant.
module rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     prio,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] grant
);

  // Walk offsets from the far end so the nearest requester to prio wins.
  always_comb begin
    int p;
    p     = 0;
    grant = '0;
    if (en) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        p = int'(prio) + i;
        if (p >= NUM_PORTS) p = p - NUM_PORTS;
        if (req[IDX_W'(p)]) begin
          grant              = '0;
          grant[IDX_W'(p)]   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// N-port AXI read arbiter: round-robin AR issue through one register stage,
// per-port outstanding-burst throttling and RID-based R routing.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int PORT_IDX_W      = port_idx_w(NUM_PORTS),
  parameter int ID_W            = 6,
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 8,
  parameter int DATA_W          = 256,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          axi_arready_in,
  output logic [PORT_IDX_W+ID_W-1:0]    axi_arid_out,
  output logic [ADDR_W-1:0]             axi_araddr_out,
  output logic [LEN_W-1:0]              axi_arlen_out,
  output logic                          axi_arvalid_out,
  input  logic [PORT_IDX_W+ID_W-1:0]    axi_rid_in,
  input  logic [DATA_W-1:0]             axi_rdata_in,
  input  logic                          axi_rlast_in,
  input  logic                          axi_rvalid_in,
  output logic                          axi_rready_out,
  input  logic [NUM_PORTS*ID_W-1:0]     rd_id_in,
  input  logic [NUM_PORTS*ADDR_W-1:0]   rd_addr_in,
  input  logic [NUM_PORTS*LEN_W-1:0]    rd_len_in,
  input  logic [NUM_PORTS-1:0]          rd_info_valid_in,
  output logic [NUM_PORTS-1:0]          rd_info_rdy_out,
  output logic [DATA_W-1:0]             rd_data_out,
  output logic [NUM_PORTS-1:0]          rd_data_valid_out,
  input  logic [NUM_PORTS-1:0]          rd_data_rdy_in,
  output logic                          err_unexpected_rid_out
);

  localparam int CNT_W = clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;
  logic [NUM_PORTS-1:0]            elig, grant, cnt_nz, r_sel, dec;
  logic [PORT_IDX_W-1:0]           prio, gidx, r_idx;
  logic                            ld, r_known, r_bad, r_done;

  assign ld    = !axi_arvalid_out || axi_arready_in;
  assign r_idx = axi_rid_in[port_lsb(ID_W) +: PORT_IDX_W];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign elig[p]   = rd_info_valid_in[p] && (cnt[p] < CNT_MAX);
    assign cnt_nz[p] = |cnt[p];
    assign r_sel[p]  = (r_idx == PORT_IDX_W'(p));
  end

  // Grant is gated by rst_n so no port sees a handshake while in reset.
  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (PORT_IDX_W)
  ) u_rr (
    .req   (elig),
    .prio  (prio),
    .en    (ld && rst_n),
    .grant (grant)
  );

  assign rd_info_rdy_out = grant;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (grant[i]) gidx = PORT_IDX_W'(i);
  end

  // A beat is only routable when its port exists and has a burst in flight;
  // anything else is swallowed so the bus cannot deadlock.
  assign r_known           = |(r_sel & cnt_nz);
  assign r_bad             = axi_rvalid_in && !r_known;
  assign axi_rready_out    = r_bad || |(r_sel & rd_data_rdy_in);
  assign rd_data_valid_out = {NUM_PORTS{axi_rvalid_in}} & r_sel & cnt_nz;
  assign rd_data_out       = axi_rdata_in;
  assign r_done            = axi_rvalid_in && axi_rready_out && axi_rlast_in && r_known;
  assign dec               = {NUM_PORTS{r_done}} & r_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[i] && !dec[i] && cnt[i] != CNT_MAX)
          cnt[i] <= cnt[i] + 1'b1;
        else if (dec[i] && !grant[i] && cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_arvalid_out        <= 1'b0;
      axi_arid_out           <= '0;
      axi_araddr_out         <= '0;
      axi_arlen_out          <= '0;
      prio                   <= '0;
      err_unexpected_rid_out <= 1'b0;
    end else begin
      if (|grant) begin
        axi_arvalid_out <= 1'b1;
        axi_arid_out    <= {gidx, rd_id_in[int'(gidx)*ID_W +: ID_W]};
        axi_araddr_out  <= rd_addr_in[int'(gidx)*ADDR_W +: ADDR_W];
        axi_arlen_out   <= rd_len_in[int'(gidx)*LEN_W +: LEN_W];
        prio            <= (int'(gidx) == NUM_PORTS - 1) ? '0 : gidx + 1'b1;
      end else if (axi_arready_in) begin
        axi_arvalid_out <= 1'b0;
      end
      if (r_bad) err_unexpected_rid_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a queue-free behavioural model.
module tb_axi_read_arbiter;
  localparam int NP = 4, IW = 6, AW = 32, LW = 8, DW = 256, MAXO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              arready, arvalid, rlast, rvalid, rready, err;
  logic [7:0]        arid, rid;
  logic [AW-1:0]     araddr;
  logic [LW-1:0]     arlen;
  logic [DW-1:0]     rdata, rd_data;
  logic [NP*IW-1:0]  rd_id;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP*LW-1:0]  rd_len;
  logic [NP-1:0]     vld, info_rdy, dv, rdy;

  axi_read_arbiter #(
    .NUM_PORTS(NP), .ID_W(IW), .ADDR_W(AW), .LEN_W(LW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_arready_in(arready), .axi_arid_out(arid), .axi_araddr_out(araddr),
    .axi_arlen_out(arlen), .axi_arvalid_out(arvalid),
    .axi_rid_in(rid), .axi_rdata_in(rdata), .axi_rlast_in(rlast),
    .axi_rvalid_in(rvalid), .axi_rready_out(rready),
    .rd_id_in(rd_id), .rd_addr_in(rd_addr), .rd_len_in(rd_len),
    .rd_info_valid_in(vld), .rd_info_rdy_out(info_rdy),
    .rd_data_out(rd_data), .rd_data_valid_out(dv), .rd_data_rdy_in(rdy),
    .err_unexpected_rid_out(err)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: bursts in flight per port, next-in-line pointer,
  // and the last address request presented on AR.
  int          m_out[NP];
  int          m_prio;
  bit          m_arv, m_err;
  logic [7:0]  m_arid;
  logic [31:0] m_addr;
  logic [7:0]  m_len;

  task automatic set_fixed();
    for (int p = 0; p < NP; p++) begin
      rd_id[p*IW +: IW]   = IW'(p + 3);
      rd_addr[p*AW +: AW] = AW'(32'h800 * p);
      rd_len[p*LW +: LW]  = LW'(p + 1);
    end
  endtask

  task automatic set_in(input logic [3:0] v, input logic ar, input logic rv,
                        input logic [7:0] id, input logic rl, input logic [3:0] r);
    vld = v; arready = ar; rvalid = rv; rid = id; rlast = rl; rdy = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(4'b1111, 1'b1, 1'b1, 8'h03, 1'b1, 4'b1111);
    #2;
    chk("rst_info_rdy", info_rdy, 0);
    chk("rst_data_vld", dv, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_arid", arid, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_arlen", arlen, 0);
    chk("rst_err", err, 0);
    for (int p = 0; p < NP; p++) m_out[p] = 0;
    m_prio = 0; m_arv = 0; m_err = 0;
    set_in(4'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: compare combinational outputs mid-cycle, then registered ones
  // just after the edge. Returns the mid-cycle samples for directed checks.
  task automatic step(output logic [3:0] s_rdy, output logic [3:0] s_dv, output logic s_rr);
    int g, port;
    bit known;
    logic [3:0] e_rdy, e_dv;
    logic e_rr;
    @(negedge clk);
    g = -1;
    if (!m_arv || arready)
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_prio + k) % NP;
        if (g < 0 && vld[p] && m_out[p] < MAXO) g = p;
      end
    e_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
    port  = int'(rid[7:6]);
    known = m_out[port] > 0;
    e_dv  = (rvalid && known) ? 4'(1 << port) : 4'b0;
    e_rr  = (rvalid && !known) ? 1'b1 : rdy[port];
    s_rdy = info_rdy; s_dv = dv; s_rr = rready;
    chk("m_info_rdy", s_rdy, e_rdy);
    chk("m_data_vld", s_dv, e_dv);
    chk("m_rready", s_rr, e_rr);
    chk("m_rdata", rd_data[63:0], rdata[63:0]);
    @(posedge clk);
    if (rvalid && e_rr && rlast && known) m_out[port]--;
    if (rvalid && !known) m_err = 1;
    if (g >= 0) begin
      m_out[g]++;
      m_prio = (g + 1) % NP;
      m_arv  = 1;
      m_arid = {2'(g), rd_id[g*IW +: IW]};
      m_addr = rd_addr[g*AW +: AW];
      m_len  = rd_len[g*LW +: LW];
    end else if (arready) begin
      m_arv = 0;
    end
    #1;
    chk("m_arvalid", arvalid, m_arv);
    if (m_arv) begin
      chk("m_arid", arid, m_arid);
      chk("m_araddr", araddr, m_addr);
      chk("m_arlen", arlen, m_len);
    end
    chk("m_err", err, m_err);
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic       ar, rv;
    logic [7:0] rid;
    logic       rl;
    logic [3:0] rdy;
    logic [3:0] e_rdy, e_dv;
    logic       e_rr, e_arv;
    logic [7:0] e_arid;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rs, input logic [3:0] v, input logic ar, input logic rv,
                     input logic [7:0] id, input logic rl, input logic [3:0] r,
                     input logic [3:0] er, input logic [3:0] ed, input logic err_r,
                     input logic ea, input logic [7:0] eid, input logic ee);
    vec_t t;
    t.rst = rs; t.vld = v; t.ar = ar; t.rv = rv; t.rid = id; t.rl = rl; t.rdy = r;
    t.e_rdy = er; t.e_dv = ed; t.e_rr = err_r; t.e_arv = ea; t.e_arid = eid; t.e_err = ee;
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] s_rdy, s_dv;
    logic       s_rr;
    rdata = '0;
    set_fixed();
    // Port p carries id p+3, addr 0x800*p, len p+1 (port 2: 5, 0x1000, 3).
    add(1, 4'b0100, 1, 0, 8'h00, 0, 4'b0000, 4'b0100, 4'b0000, 0, 1, 8'h85, 0);
    add(0, 4'b0000, 1, 0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 0);
    add(0, 4'b0000, 1, 1, 8'h85, 1, 4'b0100, 4'b0000, 4'b0100, 1, 0, 8'h00, 0);
    add(0, 4'b0000, 1, 1, 8'h85, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 8'h00, 1);
    add(0, 4'b0000, 1, 0, 8'h00, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 8'h00, 1);
    add(1, 4'b1111, 1, 0, 8'h00, 0, 4'b0000, 4'b0001, 4'b0000, 0, 1, 8'h03, 0);
    add(0, 4'b1111, 1, 0, 8'h00, 0, 4'b0000, 4'b0010, 4'b0000, 0, 1, 8'h44, 0);
    add(0, 4'b1111, 1, 0, 8'h00, 0, 4'b0000, 4'b0100, 4'b0000, 0, 1, 8'h85, 0);
    add(0, 4'b1111, 1, 0, 8'h00, 0, 4'b0000, 4'b1000, 4'b0000, 0, 1, 8'hC6, 0);
    add(0, 4'b1111, 1, 0, 8'h00, 0, 4'b0000, 4'b0001, 4'b0000, 0, 1, 8'h03, 0);
    add(0, 4'b0000, 1, 1, 8'hC3, 1, 4'b0000, 4'b0000, 4'b1000, 0, 0, 8'h00, 0);
    add(0, 4'b0000, 1, 1, 8'hC3, 1, 4'b1000, 4'b0000, 4'b1000, 1, 0, 8'h00, 0);
    add(0, 4'b0000, 1, 1, 8'hC3, 1, 4'b1000, 4'b0000, 4'b0000, 1, 0, 8'h00, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      set_in(tbl[i].vld, tbl[i].ar, tbl[i].rv, tbl[i].rid, tbl[i].rl, tbl[i].rdy);
      step(s_rdy, s_dv, s_rr);
      chk($sformatf("tbl%0d_info_rdy", i), s_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_data_vld", i), s_dv, tbl[i].e_dv);
      chk($sformatf("tbl%0d_rready", i), s_rr, tbl[i].e_rr);
      chk($sformatf("tbl%0d_arvalid", i), arvalid, tbl[i].e_arv);
      if (tbl[i].e_arv) chk($sformatf("tbl%0d_arid", i), arid, tbl[i].e_arid);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
    end

    // Stalled AR stage: outputs frozen, no grants, resumes when arready rises.
    do_reset();
    set_in(4'b0001, 0, 0, 8'h00, 0, 4'b0);
    step(s_rdy, s_dv, s_rr);
    chk("stall_first_grant", s_rdy, 4'b0001);
    set_in(4'b1111, 0, 0, 8'h00, 0, 4'b0);
    for (int c = 0; c < 5; c++) begin
      step(s_rdy, s_dv, s_rr);
      chk("stall_info_rdy", s_rdy, 4'b0000);
      chk("stall_arvalid", arvalid, 1);
      chk("stall_arid", arid, 8'h03);
      chk("stall_araddr", araddr, 32'h0);
      chk("stall_arlen", arlen, 8'h1);
    end
    arready = 1;
    step(s_rdy, s_dv, s_rr);
    chk("stall_resume_grant", s_rdy, 4'b0010);
    chk("stall_resume_arid", arid, 8'h44);

    // Outstanding limit on port 1, then release by one rlast beat.
    do_reset();
    set_in(4'b0010, 1, 0, 8'h00, 0, 4'b0);
    for (int c = 0; c < MAXO; c++) begin
      step(s_rdy, s_dv, s_rr);
      chk("sat_grant", s_rdy, 4'b0010);
    end
    step(s_rdy, s_dv, s_rr);
    chk("sat_blocked", s_rdy, 4'b0000);
    vld = 4'b0011;
    step(s_rdy, s_dv, s_rr);
    chk("sat_others_go", s_rdy, 4'b0001);
    set_in(4'b0010, 1, 1, 8'h44, 1, 4'b0010);
    step(s_rdy, s_dv, s_rr);
    chk("sat_still_blocked", s_rdy, 4'b0000);
    chk("sat_rready", s_rr, 1);
    set_in(4'b0010, 1, 0, 8'h00, 0, 4'b0);
    step(s_rdy, s_dv, s_rr);
    chk("sat_released", s_rdy, 4'b0010);

    // Sticky error cleared asynchronously by reset mid-cycle.
    do_reset();
    set_in(4'b0, 1, 1, 8'h85, 1, 4'b0100);
    step(s_rdy, s_dv, s_rr);
    chk("err_set_dv", s_dv, 4'b0000);
    chk("err_set", err, 1);
    set_in(4'b0, 1, 0, 8'h00, 0, 4'b0);
    step(s_rdy, s_dv, s_rr);
    chk("err_sticky", err, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("err_async_clear", err, 0);
    do_reset();

    // Randomized traffic against the model, with a reset halfway.
    for (int c = 0; c < 2000; c++) begin
      int pp;
      if (c == 1000) do_reset();
      vld     = 4'($urandom);
      arready = ($urandom_range(3) != 0);
      for (int p = 0; p < NP; p++) begin
        rd_id[p*IW +: IW]   = IW'($urandom);
        rd_addr[p*AW +: AW] = $urandom;
        rd_len[p*LW +: LW]  = LW'($urandom);
      end
      rvalid = ($urandom_range(2) == 0);
      rlast  = 1'($urandom);
      rdy    = 4'($urandom);
      rdata  = {8{$urandom}};
      pp = $urandom_range(NP - 1);
      if ($urandom_range(15) != 0)
        for (int k = 0; k < NP; k++)
          if (m_out[(pp + k) % NP] > 0 && m_out[pp] == 0) pp = (pp + k) % NP;
      rid = {2'(pp), 6'($urandom)};
      step(s_rdy, s_dv, s_rr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
